flex_counter_ext: RTL and testbench

//  Parametrised successor to the basic flexible counter for the USB/SD bulk-transfer datapath.
//  - Counts up or down between a programmable start value and a rollover value.
//  - Three end-of-range modes: wrap, saturate, one-shot.
//  - Config is latched on clear/load, so it cannot change mid-run.
//  - Used for byte-in-block, block-in-transfer and timeout counting in the SD/USB controllers.

---
 rtl/flex_counter_pkg.sv | 20 ++
 rtl/flex_counter_ext.sv | 99 +++++++++
 tb/tb_flex_counter_ext.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/flex_counter_pkg.sv
// Shared types for the flexible up/down counter: end-of-range modes and the
// mapping from the raw 2-bit mode input.
package flex_counter_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_ONESHOT = 2'b10
    } cnt_mode_t;

    // The unused encoding 2'b11 behaves as wrap.
    function automatic cnt_mode_t to_mode(input logic [1:0] raw);
        case (raw)
            2'b01:   return MODE_SAT;
            2'b10:   return MODE_ONESHOT;
            default: return MODE_WRAP;
        endcase
    endfunction

endpackage

// File: rtl/flex_counter_ext.sv
// Up/down counter between a latched start and rollover value with wrap,
// saturate and one-shot end-of-range behaviour plus flag/pulse/done outputs.
module flex_counter_ext
    import flex_counter_pkg::*;
#(
    parameter int                      NUM_CNT_BITS     = 4,
    parameter logic [NUM_CNT_BITS-1:0] DEFAULT_ROLLOVER = NUM_CNT_BITS'(15)
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    load,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] load_val,
    input  logic                    up_down,
    input  logic [1:0]              mode,
    input  logic [NUM_CNT_BITS-1:0] start_val,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag,
    output logic                    rollover_pulse,
    output logic                    done
);

    cnt_mode_t                cfg_mode, cfg_mode_nxt;
    logic                     cfg_up, cfg_up_nxt;
    logic [NUM_CNT_BITS-1:0]  cfg_start, cfg_start_nxt;
    logic [NUM_CNT_BITS-1:0]  cfg_roll, cfg_roll_nxt;
    logic [NUM_CNT_BITS-1:0]  terminal, reload, terminal_nxt, reload_nxt;
    logic [NUM_CNT_BITS-1:0]  count_nxt;
    logic                     flag_nxt, pulse_nxt, done_nxt;
    logic                     latch_cfg, step_ok;

    // Config register inputs: only clear/load may change the active range.
    always_comb begin
        latch_cfg     = clear | load;
        cfg_mode_nxt  = latch_cfg ? to_mode(mode) : cfg_mode;
        cfg_up_nxt    = latch_cfg ? up_down       : cfg_up;
        cfg_start_nxt = latch_cfg ? start_val     : cfg_start;
        cfg_roll_nxt  = latch_cfg ? rollover_val  : cfg_roll;

        terminal      = cfg_up     ? cfg_roll      : cfg_start;
        reload        = cfg_up     ? cfg_start     : cfg_roll;
        terminal_nxt  = cfg_up_nxt ? cfg_roll_nxt  : cfg_start_nxt;
        reload_nxt    = cfg_up_nxt ? cfg_start_nxt : cfg_roll_nxt;
    end

    always_comb begin
        count_nxt = count_out;
        pulse_nxt = 1'b0;
        done_nxt  = done;
        step_ok   = count_enable && !(cfg_mode == MODE_ONESHOT && done);

        if (clear) begin
            count_nxt = reload_nxt;
            done_nxt  = 1'b0;
        end else if (load) begin
            count_nxt = load_val;
            done_nxt  = 1'b0;
        end else if (step_ok) begin
            if (count_out != terminal) begin
                count_nxt = cfg_up ? count_out + NUM_CNT_BITS'(1)
                                   : count_out - NUM_CNT_BITS'(1);
                pulse_nxt = (count_nxt == terminal);
            end else if (cfg_mode == MODE_WRAP) begin
                // With start == roll the reload lands on the terminal again.
                count_nxt = reload;
                pulse_nxt = (reload == terminal);
            end
            if (pulse_nxt && cfg_mode == MODE_ONESHOT)
                done_nxt = 1'b1;
        end

        flag_nxt = (count_nxt == terminal_nxt);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cfg_mode       <= MODE_WRAP;
            cfg_up         <= 1'b1;
            cfg_start      <= '0;
            cfg_roll       <= DEFAULT_ROLLOVER;
            count_out      <= '0;
            rollover_flag  <= 1'b0;
            rollover_pulse <= 1'b0;
            done           <= 1'b0;
        end else begin
            cfg_mode       <= cfg_mode_nxt;
            cfg_up         <= cfg_up_nxt;
            cfg_start      <= cfg_start_nxt;
            cfg_roll       <= cfg_roll_nxt;
            count_out      <= count_nxt;
            rollover_flag  <= flag_nxt;
            rollover_pulse <= pulse_nxt;
            done           <= done_nxt;
        end
    end

endmodule

// File: tb/tb_flex_counter_ext.sv
// Scoreboard bench for flex_counter_ext: a behavioural model pushes the
// expected outputs per cycle, each scenario task pops and compares them.
module tb_flex_counter_ext;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       clear = 1'b0, load = 1'b0, count_enable = 1'b0, up_down = 1'b1;
    logic [1:0] mode = 2'b00;
    logic [3:0] load_val = '0, start_val = '0, rollover_val = 4'd15;
    logic [3:0] count_out;
    logic       rollover_flag, rollover_pulse, done;

    typedef struct packed {
        logic [3:0] cnt;
        logic       flag;
        logic       pulse;
        logic       done;
    } obs_t;

    obs_t       sb[$];
    obs_t       m, exp_o;
    logic [1:0] m_mode;
    logic       m_up;
    logic [3:0] m_start, m_roll;
    int         checks = 0, failures = 0, pulses;

    flex_counter_ext #(.NUM_CNT_BITS(4), .DEFAULT_ROLLOVER(4'd15)) dut (
        .clk(clk), .n_rst(n_rst), .clear(clear), .load(load),
        .count_enable(count_enable), .load_val(load_val), .up_down(up_down),
        .mode(mode), .start_val(start_val), .rollover_val(rollover_val),
        .count_out(count_out), .rollover_flag(rollover_flag),
        .rollover_pulse(rollover_pulse), .done(done)
    );

    always #5 clk = ~clk;

    function automatic obs_t dut_obs();
        return {count_out, rollover_flag, rollover_pulse, done};
    endfunction

    task automatic model_reset();
        m       = '0;
        m_mode  = 2'b00;
        m_up    = 1'b1;
        m_start = 4'd0;
        m_roll  = 4'd15;
    endtask

    // Reference behaviour for one clock edge given the current inputs.
    task automatic model_step();
        logic [3:0] term;
        logic [3:0] rel;
        m.pulse = 1'b0;
        if (clear || load) begin
            m_mode  = (mode == 2'b11) ? 2'b00 : mode;
            m_up    = up_down;
            m_start = start_val;
            m_roll  = rollover_val;
            m.cnt   = clear ? (m_up ? m_start : m_roll) : load_val;
            m.done  = 1'b0;
        end else if (count_enable && !(m_mode == 2'b10 && m.done)) begin
            term = m_up ? m_roll : m_start;
            rel  = m_up ? m_start : m_roll;
            if (m.cnt != term) begin
                m.cnt   = m_up ? m.cnt + 4'd1 : m.cnt - 4'd1;
                m.pulse = (m.cnt == term);
            end else if (m_mode == 2'b00) begin
                m.cnt   = rel;
                m.pulse = (rel == term);
            end
            if (m.pulse && m_mode == 2'b10) m.done = 1'b1;
        end
        m.flag = (m.cnt == (m_up ? m_roll : m_start));
    endtask

    task automatic tick(input logic c, input logic l, input logic e);
        clear = c; load = l; count_enable = e;
        model_step();
        sb.push_back(m);
        @(posedge clk); #1;
        clear = 1'b0; load = 1'b0; count_enable = 1'b0;
    endtask

    task automatic cfg(input logic up, input logic [1:0] md, input logic [3:0] st, input logic [3:0] rl);
        up_down = up; mode = md; start_val = st; rollover_val = rl;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (dut_obs() !== obs_t'(0)) begin
            failures++;
            $display("FAIL reset: got %b want %b (cnt,flag,pulse,done)", dut_obs(), obs_t'(0));
        end
        #1 n_rst = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        exp_o = sb.pop_front();
        checks++;
        if (dut_obs() !== exp_o) begin
            failures++;
            $display("FAIL reset_idle: got %b want %b", dut_obs(), exp_o);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] tbl [8] = '{4'd4, 4'd5, 4'd6, 4'd3, 4'd4, 4'd5, 4'd6, 4'd3};
        cfg(1'b1, 2'b00, 4'd3, 4'd6);
        tick(1'b1, 1'b0, 1'b0);
        exp_o = sb.pop_front();
        checks++;
        if (count_out !== 4'd3 || dut_obs() !== exp_o) begin
            failures++;
            $display("FAIL wrap_clear: got %b want %b", dut_obs(), exp_o);
        end
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 1'b0, 1'b1);
            exp_o = sb.pop_front();
            checks++;
            if (dut_obs() !== exp_o || count_out !== tbl[i]
                || rollover_pulse !== (tbl[i] == 4'd6)) begin
                failures++;
                $display("FAIL wrap step %0d: got %b want %b", i, dut_obs(), exp_o);
            end
        end
    endtask

    task automatic test_sat_down();
        cfg(1'b0, 2'b01, 4'd2, 4'd9);
        tick(1'b1, 1'b0, 1'b0);
        exp_o = sb.pop_front();
        checks++;
        if (count_out !== 4'd9 || dut_obs() !== exp_o) begin
            failures++;
            $display("FAIL sat_clear: got %b want %b", dut_obs(), exp_o);
        end
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b0, 1'b1);
            exp_o = sb.pop_front();
            pulses += int'(rollover_pulse);
            checks++;
            if (dut_obs() !== exp_o) begin
                failures++;
                $display("FAIL sat step %0d: got %b want %b", i, dut_obs(), exp_o);
            end
        end
        checks++;
        if (pulses != 1 || count_out !== 4'd2 || rollover_flag !== 1'b1) begin
            failures++;
            $display("FAIL sat_end: got pulses=%0d cnt=%0d flag=%b want 1 2 1", pulses, count_out, rollover_flag);
        end
    endtask

    task automatic test_oneshot();
        cfg(1'b1, 2'b10, 4'd0, 4'd4);
        tick(1'b1, 1'b0, 1'b0);
        void'(sb.pop_front());
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b0, 1'b1);
            exp_o = sb.pop_front();
            pulses += int'(rollover_pulse);
            checks++;
            if (dut_obs() !== exp_o) begin
                failures++;
                $display("FAIL oneshot step %0d: got %b want %b", i, dut_obs(), exp_o);
            end
        end
        checks++;
        if (pulses != 1 || count_out !== 4'd4 || done !== 1'b1) begin
            failures++;
            $display("FAIL oneshot_end: got pulses=%0d cnt=%0d done=%b want 1 4 1", pulses, count_out, done);
        end
        load_val = 4'd1;
        tick(1'b0, 1'b1, 1'b0);
        exp_o = sb.pop_front();
        checks++;
        if (count_out !== 4'd1 || done !== 1'b0 || dut_obs() !== exp_o) begin
            failures++;
            $display("FAIL oneshot_load: got %b want %b", dut_obs(), exp_o);
        end
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 1'b0, 1'b1);
            exp_o = sb.pop_front();
            checks++;
            if (dut_obs() !== exp_o) begin
                failures++;
                $display("FAIL oneshot_resume %0d: got %b want %b", i, dut_obs(), exp_o);
            end
        end
    endtask

    task automatic test_priority();
        cfg(1'b1, 2'b00, 4'd0, 4'd15);
        load_val = 4'd5;
        tick(1'b0, 1'b1, 1'b0);
        void'(sb.pop_front());
        start_val = 4'd2;
        load_val  = 4'd11;
        tick(1'b1, 1'b1, 1'b1);
        exp_o = sb.pop_front();
        checks++;
        if (count_out !== 4'd2 || rollover_pulse !== 1'b0 || dut_obs() !== exp_o) begin
            failures++;
            $display("FAIL prio_clear: got %b want %b", dut_obs(), exp_o);
        end
        load_val = 4'd9;
        tick(1'b0, 1'b1, 1'b1);
        exp_o = sb.pop_front();
        checks++;
        if (count_out !== 4'd9 || dut_obs() !== exp_o) begin
            failures++;
            $display("FAIL prio_load: got %b want %b", dut_obs(), exp_o);
        end
    endtask

    task automatic test_cfg_latch();
        logic [3:0] tbl [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0, 4'd1,
                                 4'd0, 4'd1, 4'd2, 4'd3, 4'd3};
        cfg(1'b1, 2'b00, 4'd0, 4'd5);
        tick(1'b1, 1'b0, 1'b0);
        void'(sb.pop_front());
        for (int i = 0; i < 12; i++) begin
            if (i == 3) begin
                rollover_val = 4'd3;
                mode         = 2'b01;
            end
            tick(i == 7, 1'b0, i != 7);
            exp_o = sb.pop_front();
            checks++;
            if (dut_obs() !== exp_o || count_out !== tbl[i]) begin
                failures++;
                $display("FAIL cfg_latch step %0d: got %b want %b", i, dut_obs(), exp_o);
            end
        end
    endtask

    task automatic test_reset_mid();
        cfg(1'b1, 2'b00, 4'd0, 4'd15);
        tick(1'b1, 1'b0, 1'b0);
        void'(sb.pop_front());
        repeat (7) begin
            tick(1'b0, 1'b0, 1'b1);
            void'(sb.pop_front());
        end
        checks++;
        if (count_out !== 4'd7) begin
            failures++;
            $display("FAIL pre_reset count: got %0d want 7", count_out);
        end
        #2 n_rst = 1'b0;
        #1;
        model_reset();
        checks++;
        if (dut_obs() !== obs_t'(0)) begin
            failures++;
            $display("FAIL async_reset: got %b want %b", dut_obs(), obs_t'(0));
        end
        @(posedge clk); #2 n_rst = 1'b1;
        for (int i = 0; i < 17; i++) begin
            tick(1'b0, 1'b0, 1'b1);
            exp_o = sb.pop_front();
            checks++;
            if (dut_obs() !== exp_o || count_out !== 4'((i + 1) % 16)) begin
                failures++;
                $display("FAIL post_reset step %0d: got %b want %b", i, dut_obs(), exp_o);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_wrap();
        test_sat_down();
        test_oneshot();
        test_priority();
        test_cfg_latch();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
